// File: rtl/config_pkg.sv
// Shared constants for the configuration loader: header layout, magic value
// and the frame FSM state encoding.
package config_pkg;

  localparam logic [7:0] MAGIC = 8'hC5;

  localparam int HDR_MAGIC_LSB = 24;
  localparam int HDR_MAGIC_W   = 8;
  localparam int HDR_ADDR_LSB  = 16;
  localparam int HDR_ADDR_W    = 8;
  localparam int HDR_CNT_LSB   = 0;
  localparam int HDR_CNT_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/config_checksum.sv
// XOR accumulator over one frame. The header word seeds the accumulator, so
// "clear on header" and "include header" happen in the same cycle.
module config_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] data,
  output logic [31:0] acc
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       acc <= '0;
    else if (clear) acc <= data;
    else if (en)    acc <= acc ^ data;
  end

endmodule

// File: rtl/config_loader.sv
// Streams header/data frames into per-tile config write strobes.
// Define CONFIG_LOADER_CHECKSUM_EN to require a trailing XOR checksum word.
module config_loader
  import config_pkg::*;
#(
  parameter int NUM_TILES = 16,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic [31:0]          config_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

`ifdef CONFIG_LOADER_CHECKSUM_EN
  localparam state_t POST = CHECK;
`else
  localparam state_t POST = RESP;
`endif

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr;
  logic [HDR_CNT_W-1:0]   cnt;
  logic                   bad_addr;
  logic                   fail;
  logic                   fire;
  logic                   csum_ok;
  logic [NUM_TILES-1:0]   sel;

  logic [HDR_MAGIC_W-1:0] hdr_magic;
  logic [HDR_ADDR_W-1:0]  hdr_addr;
  logic [HDR_CNT_W-1:0]   hdr_cnt;

  assign hdr_magic = in_data[HDR_MAGIC_LSB +: HDR_MAGIC_W];
  assign hdr_addr  = in_data[HDR_ADDR_LSB  +: HDR_ADDR_W];
  assign hdr_cnt   = in_data[HDR_CNT_LSB   +: HDR_CNT_W];

  assign fire     = in_valid && in_ready;
  assign in_ready = (state != RESP);
  assign busy     = (state != IDLE);
  assign done     = (state == RESP) && !fail;
  assign err      = (state == RESP) &&  fail;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [31:0] csum;

  config_checksum u_csum (
    .clk   (clk),
    .rst   (rst),
    .clear (fire && (state == IDLE)),
    .en    (fire && (state == DATA)),
    .data  (in_data),
    .acc   (csum)
  );

  assign csum_ok = (in_data == csum);
`else
  assign csum_ok = 1'b1;
`endif

  for (genvar i = 0; i < NUM_TILES; i++) begin : g_sel
    assign sel[i] = (addr == ADDR_W'(i));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fire) begin
        if (hdr_magic != MAGIC)      state_nxt = RESP;
        else if (hdr_cnt == '0)      state_nxt = POST;
        else                         state_nxt = DATA;
      end
      DATA:  if (fire && (cnt == HDR_CNT_W'(1))) state_nxt = POST;
      CHECK: if (fire) state_nxt = RESP;
      RESP:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Out-of-range tiles still consume their words but never strobe or
  // disturb config_data, which must hold whenever config_en is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr        <= '0;
      cnt         <= '0;
      bad_addr    <= 1'b0;
      fail        <= 1'b0;
      config_en   <= '0;
      config_data <= '0;
    end else begin
      config_en <= '0;
      case (state)
        IDLE: if (fire) begin
          fail <= (hdr_magic != MAGIC);
          if (hdr_magic == MAGIC) begin
            addr     <= ADDR_W'(hdr_addr);
            cnt      <= hdr_cnt;
            bad_addr <= (32'(hdr_addr) >= 32'(NUM_TILES));
          end
        end
        DATA: if (fire) begin
          cnt <= cnt - HDR_CNT_W'(1);
          if (!bad_addr) begin
            config_en   <= sel;
            config_data <= in_data;
          end
          if (cnt == HDR_CNT_W'(1)) fail <= bad_addr;
        end
        CHECK: if (fire) fail <= fail | !csum_ok;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Scoreboard bench: stimulus pushes expected writes/responses derived from the
// frame rules; a negedge monitor pops and compares whatever the DUT emits.
module tb_config_loader;

  localparam int NT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [NT-1:0] config_en;
  logic [31:0]   config_data;
  logic          busy, done, err;

  config_loader #(.NUM_TILES(NT), .ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .config_en(config_en), .config_data(config_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // kind: 0 = tile write, 1 = done, 2 = err
  typedef struct {
    int            kind;
    logic [NT-1:0] en;
    logic [31:0]   data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endfunction

  // Monitor
  logic [31:0] last_data = '0;
  always @(negedge clk) begin
    ev_t e;
    if (rst) begin
      if (config_en != '0) begin
        if (exp_q.size() == 0) chk("spurious write", 64'(config_en), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("event kind (write)", 64'(0), 64'(e.kind));
          chk("config_en", 64'(config_en), 64'(e.en));
          chk("config_data", 64'(config_data), 64'(e.data));
        end
      end else begin
        chk("config_data hold", 64'(config_data), 64'(last_data));
      end
      if (done || err) begin
        if (exp_q.size() == 0) chk("spurious resp", 64'({done, err}), 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("done/err", 64'({done, err}), (e.kind == 1) ? 64'b10 : (e.kind == 2) ? 64'b01 : 64'b00);
        end
      end
    end
    last_data = config_data;
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = w;
      if (in_ready) begin
        @(posedge clk);
        break;
      end
      n++;
      if (n > 50) begin
        chk("in_ready timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = $urandom;
    end
  endtask

  function automatic void push(input int kind, input logic [NT-1:0] en, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.en = en; e.data = d;
    exp_q.push_back(e);
  endfunction

  // Reference model: one frame as described by its header fields.
  // gapn < 0 gives random stalls of 0..3 cycles between words.
  task automatic frame(input logic [7:0] magic, input logic [7:0] addr,
                       input logic [15:0] n, input bit fixed, input logic [31:0] fword,
                       input logic [31:0] cmask, input int gapn);
    logic [31:0]   hdr, sum, w;
    logic [NT-1:0] en;
    bit            ok;
    hdr = {magic, addr, n};
    send(hdr);
    if (magic != 8'hC5) begin
      push(2, '0, '0);
      idle((gapn < 0) ? $urandom_range(0, 3) : gapn);
      return;
    end
    sum = hdr;
    ok  = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      idle((gapn < 0) ? $urandom_range(0, 3) : gapn);
      w = fixed ? fword : $urandom;
      sum ^= w;
      send(w);
      if (int'(addr) < NT) begin
        en = '0;
        en[addr[3:0]] = 1'b1;
        push(0, en, w);
      end else ok = 1'b0;
    end
`ifdef CONFIG_LOADER_CHECKSUM_EN
    idle((gapn < 0) ? $urandom_range(0, 3) : gapn);
    send(sum ^ cmask);
    if (cmask != '0) ok = 1'b0;
`endif
    push(ok ? 1 : 2, '0, '0);
    idle((gapn < 0) ? $urandom_range(0, 3) : gapn);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   w;
    logic [NT-1:0] en;
    logic [7:0]    mg;

    #1;
    chk("reset config_en",   64'(config_en),   64'd0);
    chk("reset config_data", 64'(config_data), 64'd0);
    chk("reset busy",        64'(busy),        64'd0);
    chk("reset done",        64'(done),        64'd0);
    chk("reset err",         64'(err),         64'd0);
    chk("reset in_ready",    64'(in_ready),    64'd1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;

    // Tile 3, one word
    frame(8'hC5, 8'h03, 16'd1, 1'b1, 32'h1234_5678, 32'h0, 1);
    // Tile 0, three words with two-cycle stalls between them
    frame(8'hC5, 8'h00, 16'd3, 1'b0, 32'h0, 32'h0, 2);
    // Bad magic, then a normal frame
    frame(8'hA5, 8'h00, 16'd1, 1'b0, 32'h0, 32'h0, 1);
    frame(8'hC5, 8'h07, 16'd2, 1'b0, 32'h0, 32'h0, 0);
    // Out-of-range tile
    frame(8'hC5, 8'h20, 16'd2, 1'b0, 32'h0, 32'h0, 1);
    // Empty frame
    frame(8'hC5, 8'h05, 16'd0, 1'b0, 32'h0, 32'h0, 1);
`ifdef CONFIG_LOADER_CHECKSUM_EN
    frame(8'hC5, 8'h02, 16'd1, 1'b1, 32'h0000_00FF, 32'h0, 1);
    frame(8'hC5, 8'h02, 16'd1, 1'b1, 32'h0000_00FF, 32'hC502_00FE, 1);
`endif

    // Reset in the middle of a two-word frame
    send(32'hC505_0002);
    w = $urandom;
    send(w);
    en = '0; en[5] = 1'b1;
    push(0, en, w);
    @(negedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid-frame reset config_en",   64'(config_en),   64'd0);
    chk("mid-frame reset config_data", 64'(config_data), 64'd0);
    chk("mid-frame reset busy",        64'(busy),        64'd0);
    chk("mid-frame reset done/err",    64'({done, err}), 64'd0);
    exp_q.delete();
    @(negedge clk);
    #1 rst = 1'b1;
    frame(8'hC5, 8'h01, 16'd1, 1'b0, 32'h0, 32'h0, 0);

    // Random frames
    for (int f = 0; f < 60; f++) begin
      mg = 8'hC5;
      if ($urandom_range(0, 5) == 0) begin
        mg = 8'($urandom_range(0, 255));
        if (mg == 8'hC5) mg = 8'h5C;
      end
      frame(mg, 8'($urandom_range(0, 19)), 16'($urandom_range(0, 4)), 1'b0, 32'h0,
            ($urandom_range(0, 3) == 0) ? ($urandom | 32'h1) : 32'h0, -1);
    end

    idle(6);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
